dict_arbiter: RTL and testbench

- Sequences and shares the single string-to-integer dictionary port between NUM_REQ requesters, e.g. the interpreter, the compiler and the word-definition unit.
- Uses round-robin grant with one transaction outstanding at a time.
- Latches the granted request, drives the dictionary handshake and waits for done with a timeout guard.
- Returns the result with a one-cycle ack to the granted requester.

---
 rtl/dict_arbiter.sv | 174 +++++++++++++++++
 tb/tb_dict_arbiter.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/dict_arbiter.sv
// Round-robin arbiter sharing one string-to-integer dictionary port between
// NUM_REQ requesters. One transaction in flight; a timeout guards a stuck
// dictionary. Every output comes straight from a flop.
module dict_arbiter #(
  parameter int unsigned NUM_REQ     = 2,
  parameter int unsigned KEY_WIDTH   = 8,
  parameter int unsigned KEY_LENGTH  = 8,
  parameter int unsigned VALUE_WIDTH = 32,
  parameter int unsigned TIMEOUT     = 255
) (
  input  logic                                   i_clk,
  input  logic                                   i_rst_n,
  input  logic [NUM_REQ-1:0]                     i_req,
  input  logic [NUM_REQ-1:0]                     i_op,
  input  logic [NUM_REQ*KEY_WIDTH*KEY_LENGTH-1:0] i_key,
  input  logic [NUM_REQ*VALUE_WIDTH-1:0]         i_value,
  output logic [NUM_REQ-1:0]                     o_ack,
  output logic [VALUE_WIDTH-1:0]                 o_rdata,
  output logic                                   o_err,
  output logic [NUM_REQ-1:0]                     o_grant,
  output logic                                   o_busy,
  output logic                                   o_dict_en,
  output logic                                   o_dict_op,
  output logic [KEY_WIDTH*KEY_LENGTH-1:0]        o_dict_key,
  output logic [VALUE_WIDTH-1:0]                 o_dict_value,
  input  logic                                   i_dict_done,
  input  logic [VALUE_WIDTH-1:0]                 i_dict_value
);

  localparam int unsigned KeyW = KEY_WIDTH * KEY_LENGTH;
  localparam int unsigned IdxW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  // Last counter value of a WAIT cycle that may still end without timing out.
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

  typedef enum logic [1:0] {StIdle, StWait, StAck} state_e;

  state_e                 state_q, state_d;
  logic [NUM_REQ-1:0]     ack_q, ack_d;
  logic [NUM_REQ-1:0]     grant_q, grant_d;
  logic [VALUE_WIDTH-1:0] rdata_q, rdata_d;
  logic                   err_q, err_d;
  logic                   busy_q, busy_d;
  logic                   dict_en_q, dict_en_d;
  logic                   dict_op_q, dict_op_d;
  logic [KeyW-1:0]        dict_key_q, dict_key_d;
  logic [VALUE_WIDTH-1:0] dict_value_q, dict_value_d;
  logic [IdxW-1:0]        last_grant_q, last_grant_d;
  logic [CntW-1:0]        cnt_q, cnt_d;

  logic                   pick_valid;
  logic [IdxW-1:0]        pick_idx;
  logic [IdxW-1:0]        cand;
  int unsigned            idx;
  int unsigned            sel;

  // Round-robin search: first set request upward from last_grant+1, wrapping.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    idx        = 0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      idx  = (32'(last_grant_q) + 32'd1 + i) % NUM_REQ;
      cand = IdxW'(idx);
      if (!pick_valid && i_req[cand]) begin
        pick_valid = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  // Transaction FSM: next state and all registered outputs.
  always_comb begin
    state_d      = state_q;
    ack_d        = '0;
    grant_d      = grant_q;
    rdata_d      = rdata_q;
    err_d        = err_q;
    busy_d       = busy_q;
    dict_en_d    = dict_en_q;
    dict_op_d    = dict_op_q;
    dict_key_d   = dict_key_q;
    dict_value_d = dict_value_q;
    last_grant_d = last_grant_q;
    cnt_d        = cnt_q;
    sel          = 32'(pick_idx);

    unique case (state_q)
      StIdle: begin
        if (pick_valid) begin
          state_d      = StWait;
          grant_d      = {{(NUM_REQ-1){1'b0}}, 1'b1} << pick_idx;
          busy_d       = 1'b1;
          dict_en_d    = 1'b1;
          dict_op_d    = i_op[pick_idx];
          dict_key_d   = i_key[sel*KeyW +: KeyW];
          dict_value_d = i_value[sel*VALUE_WIDTH +: VALUE_WIDTH];
          last_grant_d = pick_idx;
          cnt_d        = '0;
        end
      end
      StWait: begin
        // Done is checked first so it wins over a coincident timeout.
        if (i_dict_done) begin
          state_d   = StAck;
          dict_en_d = 1'b0;
          rdata_d   = dict_op_q ? i_dict_value : '0;
          err_d     = 1'b0;
          ack_d     = grant_q;
        end else if ((TIMEOUT != 0) && (cnt_q == CntLast)) begin
          state_d   = StAck;
          dict_en_d = 1'b0;
          rdata_d   = '0;
          err_d     = 1'b1;
          ack_d     = grant_q;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StAck: begin
        state_d = StIdle;
        grant_d = '0;
        busy_d  = 1'b0;
        err_d   = 1'b0;
        rdata_d = '0;
        cnt_d   = '0;
      end
      default: state_d = StIdle;
    endcase
  end

  // State register; reset points the round-robin search at requester 0.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= StIdle;
      ack_q        <= '0;
      grant_q      <= '0;
      rdata_q      <= '0;
      err_q        <= 1'b0;
      busy_q       <= 1'b0;
      dict_en_q    <= 1'b0;
      dict_op_q    <= 1'b0;
      dict_key_q   <= '0;
      dict_value_q <= '0;
      last_grant_q <= IdxW'(NUM_REQ - 1);
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      ack_q        <= ack_d;
      grant_q      <= grant_d;
      rdata_q      <= rdata_d;
      err_q        <= err_d;
      busy_q       <= busy_d;
      dict_en_q    <= dict_en_d;
      dict_op_q    <= dict_op_d;
      dict_key_q   <= dict_key_d;
      dict_value_q <= dict_value_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
    end
  end

  assign o_ack        = ack_q;
  assign o_rdata      = rdata_q;
  assign o_err        = err_q;
  assign o_grant      = grant_q;
  assign o_busy       = busy_q;
  assign o_dict_en    = dict_en_q;
  assign o_dict_op    = dict_op_q;
  assign o_dict_key   = dict_key_q;
  assign o_dict_value = dict_value_q;

endmodule

// File: tb/tb_dict_arbiter.sv
// Directed bench for dict_arbiter: two requesters, TIMEOUT of 4 cycles.
module tb_dict_arbiter;

  localparam logic [63:0] KeyDup = 64'h0000_0000_0044_5550;  // "DUP"
  localparam logic [63:0] KeyK1  = 64'h0000_0000_4b45_5931;  // "KEY1"

  logic         clk;
  logic         rst_n;
  logic [1:0]   req;
  logic [1:0]   op;
  logic [127:0] key;
  logic [63:0]  value;
  logic [1:0]   ack;
  logic [31:0]  rdata;
  logic         err;
  logic [1:0]   grant;
  logic         busy;
  logic         dict_en;
  logic         dict_op;
  logic [63:0]  dict_key;
  logic [31:0]  dict_value;
  logic         dict_done;
  logic [31:0]  dict_rvalue;

  int n_checks = 0;
  int n_errors = 0;

  dict_arbiter #(
    .NUM_REQ    (2),
    .KEY_WIDTH  (8),
    .KEY_LENGTH (8),
    .VALUE_WIDTH(32),
    .TIMEOUT    (4)
  ) u_dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_req       (req),
    .i_op        (op),
    .i_key       (key),
    .i_value     (value),
    .o_ack       (ack),
    .o_rdata     (rdata),
    .o_err       (err),
    .o_grant     (grant),
    .o_busy      (busy),
    .o_dict_en   (dict_en),
    .o_dict_op   (dict_op),
    .o_dict_key  (dict_key),
    .o_dict_value(dict_value),
    .i_dict_done (dict_done),
    .i_dict_value(dict_rvalue)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Called in an IDLE cycle with req already driven. done_cyc is the WAIT
  // cycle (1-based) in which the dictionary pulses done; 0 means never.
  task automatic run_txn(input logic [1:0] exp_grant, input int done_cyc, input logic exp_op,
                         input logic [63:0] exp_key, input logic [31:0] exp_val,
                         input logic [31:0] dval, input logic [31:0] exp_rdata,
                         input logic exp_err, input int exp_waits, input logic [1:0] req_after,
                         input logic scramble);
    int waits;
    step();
    check("grant", 64'(grant), 64'(exp_grant));
    check("busy_wait", 64'(busy), 64'd1);
    check("dict_op", 64'(dict_op), 64'(exp_op));
    check("dict_value", 64'(dict_value), 64'(exp_val));
    waits = 0;
    while (ack == 2'b00 && waits < 20) begin
      if (scramble && waits == 0) key = ~key;
      dict_done   = (waits + 1 == done_cyc);
      dict_rvalue = dval;
      check("dict_en_wait", 64'(dict_en), 64'd1);
      check("dict_key", dict_key, exp_key);
      waits++;
      step();
    end
    dict_done = 1'b0;
    check("wait_cycles", 64'(waits), 64'(exp_waits));
    check("ack", 64'(ack), 64'(exp_grant));
    check("rdata", 64'(rdata), 64'(exp_rdata));
    check("err", 64'(err), 64'(exp_err));
    check("dict_en_ack", 64'(dict_en), 64'd0);
    check("busy_ack", 64'(busy), 64'd1);
    req = req_after;
    step();
    check("ack_clr", 64'(ack), 64'd0);
    check("busy_clr", 64'(busy), 64'd0);
    check("grant_clr", 64'(grant), 64'd0);
    check("rdata_clr", 64'(rdata), 64'd0);
    check("err_clr", 64'(err), 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n       = 1'b0;
    req         = 2'b00;
    op          = 2'b00;
    key         = '0;
    value       = '0;
    dict_done   = 1'b0;
    dict_rvalue = '0;
    #23;
    check("rst_ack", 64'(ack), 64'd0);
    check("rst_grant", 64'(grant), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_dict_en", 64'(dict_en), 64'd0);
    check("rst_rdata", 64'(rdata), 64'd0);
    check("rst_dict_key", dict_key, 64'd0);
    step();
    rst_n = 1'b1;
    step();

    // Single get from requester 0.
    op    = 2'b01;
    key   = {KeyK1, KeyDup};
    value = {32'hDEADBEEF, 32'h1111_1111};
    req   = 2'b01;
    run_txn(2'b01, 2, 1'b1, KeyDup, 32'h1111_1111, 32'h2A, 32'h2A, 1'b0, 2, 2'b00, 1'b0);

    // Set from requester 1: dictionary result must not leak into rdata.
    req = 2'b10;
    run_txn(2'b10, 3, 1'b0, KeyK1, 32'hDEADBEEF, 32'h55, 32'h0, 1'b0, 3, 2'b00, 1'b0);

    // Both requesting continuously: grants alternate starting at 0.
    req = 2'b11;
    run_txn(2'b01, 2, 1'b1, KeyDup, 32'h1111_1111, 32'h100, 32'h100, 1'b0, 2, 2'b11, 1'b0);
    run_txn(2'b10, 2, 1'b0, KeyK1, 32'hDEADBEEF, 32'h200, 32'h0, 1'b0, 2, 2'b11, 1'b0);
    run_txn(2'b01, 3, 1'b1, KeyDup, 32'h1111_1111, 32'h300, 32'h300, 1'b0, 3, 2'b11, 1'b0);
    run_txn(2'b10, 2, 1'b0, KeyK1, 32'hDEADBEEF, 32'h400, 32'h0, 1'b0, 2, 2'b00, 1'b0);

    // Key changed after grant: latched key must hold.
    req = 2'b01;
    run_txn(2'b01, 3, 1'b1, KeyDup, 32'h1111_1111, 32'h77, 32'h77, 1'b0, 3, 2'b00, 1'b1);
    key = {KeyK1, KeyDup};

    // Timeout with no done, then a normal transaction.
    req = 2'b10;
    run_txn(2'b10, 0, 1'b0, KeyK1, 32'hDEADBEEF, 32'h99, 32'h0, 1'b1, 4, 2'b00, 1'b0);
    req = 2'b01;
    run_txn(2'b01, 2, 1'b1, KeyDup, 32'h1111_1111, 32'h5A, 32'h5A, 1'b0, 2, 2'b00, 1'b0);

    // Done in the same cycle the timeout would fire: done wins.
    op  = 2'b11;
    req = 2'b10;
    run_txn(2'b10, 4, 1'b1, KeyK1, 32'hDEADBEEF, 32'hCAFE, 32'hCAFE, 1'b0, 4, 2'b00, 1'b0);

    // Reset mid-WAIT: requester 0 owns; without reset 1 would be next.
    req = 2'b11;
    step();
    check("pre_rst_grant", 64'(grant), 64'(2'b01));
    check("pre_rst_dict_en", 64'(dict_en), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_dict_en", 64'(dict_en), 64'd0);
    check("async_rst_grant", 64'(grant), 64'd0);
    check("async_rst_busy", 64'(busy), 64'd0);
    check("async_rst_dict_key", dict_key, 64'd0);
    dict_done   = 1'b1;
    dict_rvalue = 32'hBAD;
    step();
    check("rst_no_ack", 64'(ack), 64'd0);
    req   = 2'b00;
    rst_n = 1'b1;
    step();
    // Late done while idle must be ignored.
    check("late_done_ack", 64'(ack), 64'd0);
    check("late_done_busy", 64'(busy), 64'd0);
    dict_done = 1'b0;
    req       = 2'b11;
    run_txn(2'b01, 2, 1'b1, KeyDup, 32'h1111_1111, 32'h3C, 32'h3C, 1'b0, 2, 2'b00, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
